bram_port_arbiter: RTL
======================

# bram_port_arbiter

Multi-master arbiter that shares one port of a latency-modelled dual-port block RAM between `NUM_MASTERS` bus masters, such as instruction fetch, data load/store and DMA. It sits directly upstream of the RAM port. It grants one master at a time, forwards that master's request unchanged, and holds it until the RAM signals ready. After each transaction it drops the request for exactly one cycle, so the RAM's latency counter restarts before the next access.

## Interface
Parameters:
- `WIDTH`, 32, data width of the RAM port.
- `NUM_MASTERS`, 2, number of masters; legal range 2..8.

Ports:
- `i_clock`  in  1  — single clock; all state on its rising edge.
- `i_reset`  in  1  — asynchronous, active-high reset.
- `i_m_request`  in  NUM_MASTERS  — per-master request; held high until that master's `o_m_ready`.
- `i_m_rw`  in  NUM_MASTERS  — per-master direction; 0 = read, 1 = write.
- `i_m_address`  in  NUM_MASTERS*32  — packed byte addresses; master m occupies bits [m*32 +: 32].
- `i_m_wdata`  in  NUM_MASTERS*WIDTH  — packed write data.
- `o_m_rdata`  out  WIDTH  — read data, broadcast to all masters.
- `o_m_ready`  out  NUM_MASTERS  — per-master completion strobe, one-hot or zero.
- `o_request`  out  1  — RAM port request.
- `o_rw`  out  1  — RAM port direction.
- `o_address`  out  32  — RAM port address.
- `o_wdata`  out  WIDTH  — RAM port write data.
- `i_rdata`  in  WIDTH  — RAM port read data.
- `i_ready`  in  1  — RAM port ready; stays high while the request is held.

## Operation
- The state machine has three states: IDLE, ACTIVE and RELEASE.
- IDLE:
  - If any `i_m_request` bit is set, latch the winner into `grant` (index, $clog2(NUM_MASTERS) bits) and go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE:
  - `o_request` = 1.
  - `o_rw`, `o_address` and `o_wdata` are combinational muxes from the granted master, so they track that master's live inputs.
  - On `i_ready` = 1, go to RELEASE.
- RELEASE:
  - `o_request` = 0 for exactly one cycle, then go to IDLE.
  - Guarantees the RAM sees request low and resets its latency counter.
- Completion outputs:
  - `o_m_ready[grant]` = `i_ready` while in ACTIVE; every other bit is 0.
  - `o_m_rdata` = `i_rdata`, unconditionally.
  - Masters sample `o_m_rdata` only while their `o_m_ready` is high.
- Master protocol: a master must drop, or replace, its request in the cycle after its `o_m_ready`. The RELEASE cycle masks any stale request seen in that cycle.
- If the granted master drops its request while in ACTIVE (protocol violation): the arbiter keeps `o_request` = 1 until `i_ready`, then discards the completion. `o_m_ready` stays 0 for that master.
- Simultaneous requests: resolved by the priority policy (see Configuration). A master that loses stays pending without penalty.
- All outputs are valid in the same cycle as the state they depend on.

## Timing
- Reset values: `state` = IDLE, `grant` = 0, round-robin pointer = 0.
- Outputs under reset: `o_request` = 0, `o_m_ready` = 0. `o_rw`, `o_address` and `o_wdata` mux from master 0, don't-care.
- Reset asserted mid-ACTIVE forces IDLE asynchronously and drops `o_request` in the same cycle. The in-flight transfer is abandoned and no `o_m_ready` is produced.
- Master request first sampled at edge N:
  - `o_request` high in cycle N+1.
  - `o_m_ready` in the same cycle as `i_ready`.
- Back-to-back cost: 2 arbiter cycles (IDLE + RELEASE) per transaction, on top of RAM latency.
- With RAM `LATENCY` = L, a single access takes L+2 cycles from first sample to ready. The next grant comes at ready+2.

## Configuration
- Macro: `BRAM_ARBITER_ROUND_ROBIN_EN`.
- Defined (round-robin):
  - A round-robin pointer holds the index after the last completed grant.
  - The winner is the first requester at or above the pointer, with wrap-around from NUM_MASTERS-1 to 0.
  - The pointer advances when the arbiter enters RELEASE. It does not advance on a discarded completion.
- Undefined (fixed priority): the lowest index always wins and no pointer register exists.

## Structure
- Shared package `bram_arbiter_pkg`: the state enum typedef (IDLE/ACTIVE/RELEASE, 2 bits) and a `MAX_MASTERS` = 8 constant.
- One sub-module, `arbiter_pick`: purely combinational. Inputs are the request vector and the pointer; outputs are the winner index and a valid flag. Fixed priority is the same picker with the pointer tied to 0.

## Test plan
- Single read: master 1 reads 0x100, RAM L=3 returns 0xDEADBEEF.
  - `o_request` high 4 cycles.
  - `o_m_ready` = 2'b10 for one cycle with `o_m_rdata` = 0xDEADBEEF.
  - `o_request` low the next cycle.
- Write then read: master 0 writes 0x55AA55AA to 0x40, then reads 0x40 → reads back 0x55AA55AA. At least one `o_request`-low cycle occurs between the two accesses.
- Contention, round-robin build: masters 0 and 1 request continuously for 6 transactions → grant order 0,1,0,1,0,1. Fixed-priority build: master 0 only.
- Wrap-around: NUM_MASTERS=4, requesters 3 and 0, pointer at 3 → grant order 3,0,3.
- Reset mid-ACTIVE: assert `i_reset` two cycles into a read → `o_request` falls in the same cycle and `o_m_ready` never pulses. After release, a fresh request completes normally.
- Request dropped early: master 0 deasserts during ACTIVE → `o_request` held until `i_ready`, `o_m_ready` stays 0, then the arbiter returns to IDLE.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared state encoding and sizing limits for the BRAM port arbiter
package bram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
  localparam int MAX_MASTERS = 8;
endpackage

// File: rtl/arbiter_pick.sv
// arbiter_pick: combinational picker, first requester at or above the pointer with wrap-around
module arbiter_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_request,
  input  logic [IW-1:0] i_pointer,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);
  // scan from the farthest offset down so the nearest requester to the pointer wins
  always_comb begin
    logic [IW-1:0] w_idx;
    w_idx = '0;
    o_index = '0;
    o_valid = |i_request;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(i_pointer) + k) % N);
      if (i_request[w_idx]) o_index = w_idx;
    end
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port among masters; BRAM_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed priority
module bram_port_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_MASTERS = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NUM_MASTERS-1:0]       i_m_request,
  input  logic [NUM_MASTERS-1:0]       i_m_rw,
  input  logic [NUM_MASTERS*32-1:0]    i_m_address,
  input  logic [NUM_MASTERS*WIDTH-1:0] i_m_wdata,
  output logic [WIDTH-1:0]             o_m_rdata,
  output logic [NUM_MASTERS-1:0]       o_m_ready,
  output logic                         o_request,
  output logic                         o_rw,
  output logic [31:0]                  o_address,
  output logic [WIDTH-1:0]             o_wdata,
  input  logic [WIDTH-1:0]             i_rdata,
  input  logic                         i_ready
);
  localparam int GW = $clog2(NUM_MASTERS);
  state_t        r_state, w_next;
  logic [GW-1:0] r_grant, w_pick, w_ptr;
  logic          w_valid, r_dropped, w_abort;

  arbiter_pick #(.N(NUM_MASTERS), .IW(GW)) u_pick (
    .i_request(i_m_request),
    .i_pointer(w_ptr),
    .o_index  (w_pick),
    .o_valid  (w_valid)
  );

  // a completion is discarded once the granted master has let go of its request
  assign w_abort = r_dropped | ~i_m_request[r_grant];

`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
  logic [GW-1:0] r_ptr;
  // pointer moves past the winner only on a completion that was delivered
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_ptr <= '0;
    else if (r_state == ACTIVE && i_ready && !w_abort)
      r_ptr <= (int'(r_grant) == NUM_MASTERS - 1) ? '0 : r_grant + 1'b1;
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state: grant from IDLE, hold until RAM ready, one forced RELEASE cycle
  always_comb begin
    w_next = (r_state == IDLE)   ? (w_valid ? ACTIVE : IDLE) :
             (r_state == ACTIVE) ? (i_ready ? RELEASE : ACTIVE) : IDLE;
  end

  // latch the winner and remember whether it dropped its request mid-transfer
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_grant   <= '0;
      r_dropped <= 1'b0;
    end else if (r_state == IDLE && w_valid) begin
      r_grant   <= w_pick;
      r_dropped <= 1'b0;
    end else if (r_state == ACTIVE && !i_m_request[r_grant]) begin
      r_dropped <= 1'b1;
    end
  end

  // outputs: RAM port follows the granted master live, completion routed back to it
  always_comb begin
    o_m_ready          = '0;
    o_m_ready[r_grant] = (r_state == ACTIVE) & i_ready & ~w_abort;
    o_request          = (r_state == ACTIVE);
    o_rw               = i_m_rw[r_grant];
    o_address          = i_m_address[int'(r_grant)*32 +: 32];
    o_wdata            = i_m_wdata[int'(r_grant)*WIDTH +: WIDTH];
  end

  assign o_m_rdata = i_rdata;
endmodule
